axi_mst_wr_stream: RTL
======================

// Module: axi_mst_wr_stream
// PURPOSE
//  Parametrised successor AXI write master: user commands and per-beat write data arrive as separate streams (no whole-burst bus).
//  Queues up to OST_DEPTH outstanding bursts; issues AW, streams W with generated WLAST, retires B in order to a user response port.
//  Sits between the user write engine and the AXI interconnect, in place of the whole-burst write master.
// PARAMETERS
//  ID_W        4    AWID/BID width
//  ADDR_W      32   AWADDR width
//  DATA_W      64   WDATA width, power of 2, >= 8; WSTRB = DATA_W/8
//  OST_DEPTH   8    outstanding bursts, power of 2, >= 2
//  TIMEOUT_CYC 1024 B-response watchdog limit in cycles (used only with AXI_MST_WR_TIMEOUT_EN)
// PORTS
//  clk           in   1         clock
//  rst           in   1         synchronous reset, active-high
//  cmd_valid/ready  in/out 1    user command handshake
//  cmd_id/addr   in   ID_W/ADDR_W  burst ID/address
//  cmd_len/size/burst in 8/3/2   AXI len (beats-1), size, burst type
//  wd_valid/ready   in/out 1    user write-beat handshake
//  wd_data/strb  in   DATA_W/DATA_W/8  beat payload
//  awid..awburst out  per AXI   AW payload of head-of-AW entry
//  awvalid/awready  out/in 1    AW handshake
//  wdata/wstrb/wlast out DATA_W/DATA_W/8/1  W payload
//  wvalid/wready out/in 1       W handshake
//  bid/bresp     in   ID_W/2    B payload
//  bvalid/bready in/out 1       B handshake
//  rsp_valid/ready  out/in 1    user completion handshake
//  rsp_id/rsp_resp  out ID_W/2  completion ID and BRESP
//  ost_cnt       out  clog2(OST_DEPTH)+1  bursts accepted but not retired
//  err_id        out  1         one-cycle pulse: bid != queued ID on B handshake
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. Reset clears all pointers/counters; outputs reset to: cmd_ready=1, awvalid=0, wvalid=0, wlast=0, bready=0, rsp_valid=0, ost_cnt=0, err_id=0, timeout_err=0. Reset mid-burst abandons all in-flight state.
//  - Circular queue, 4 pointers (alloc, aw, w, b), width clog2(OST_DEPTH), wrap modulo OST_DEPTH. Stage counters: aw_pend, w_pend, b_pend.
//  - cmd accept: cmd_valid&cmd_ready; cmd_ready = (ost_cnt < OST_DEPTH), computed from the registered count. A B retire in the same cycle does not open a slot until the next cycle.
//  - AW: awvalid = aw_pend!=0; payload = entry[aw_ptr]; held stable until awready. AW may be issued the cycle after command capture (latency 1).
//  - W: a burst's data is sent only after its AW handshake completes (w_pend counts AW-done bursts). Bursts are sent in AW order.
//  - W is combinational pass-through: wvalid = wd_valid & w_pend!=0; wd_ready = wready & w_pend!=0; wdata/wstrb = wd_data/wd_strb.
//  - beat_cnt (8b) increments on each W handshake. wlast = wvalid & beat_cnt==len[w_ptr]. On wlast handshake, beat_cnt clears to 0 and w_ptr advances.
//  - B: bready = rsp_ready & b_pend!=0; rsp_valid = bvalid & b_pend!=0; rsp_id = id[b_ptr]; rsp_resp = bresp.
//  - On B handshake, b_ptr advances and ost_cnt decrements. Responses are retired strictly in order; bid != id[b_ptr] pulses err_id and the entry is still retired.
//  - Simultaneous events: accept + retire in one cycle leaves ost_cnt unchanged. AW handshake + wlast in one cycle updates both aw_pend and w_pend in that cycle (w_pend net 0).
//  - len=0: a single beat with wlast asserted. Counters never over- or underflow: OST_DEPTH bounds all stage counts.
// CONFIGURATION
//  AXI_MST_WR_TIMEOUT_EN defined:
//   - Adds port timeout_err (out, 1) and a watchdog counter.
//   - Counter increments while b_pend!=0 and no B handshake occurs; it clears on B handshake or when b_pend==0.
//   - When the counter reaches TIMEOUT_CYC-1, timeout_err is set sticky until rst. Traffic is unaffected.
//  Undefined: no port, no counter; behaviour is otherwise identical.
// TESTING
//  1 Single burst id=3 addr=0x100 len=3: 4 wd beats, awready=1 -> AW 1 cycle after cmd; wlast only on 4th beat; rsp id=3 resp=0.
//  2 Fill: 8 cmds with awready=0 -> cmd_ready=0 after 8th; one B retire -> cmd_ready=1 the following cycle, not the same cycle.
//  3 Backpressure: wready toggles 1/0 over len=7 burst -> wdata matches wd_data beat-by-beat; exactly 8 handshakes; beat_cnt wraps to 0.
//  4 Order: ids 1,2 issued; bid=2 first -> err_id pulse, rsp_id=1; second B bid=2 -> no error.
//  5 Simultaneous: accept + B retire in same cycle at ost_cnt=5 -> ost_cnt stays 5; rst mid-burst -> all outputs at reset values next cycle.
//  6 (AXI_MST_WR_TIMEOUT_EN, TIMEOUT_CYC=16) withhold bvalid 16 cycles after wlast -> timeout_err=1, sticky until rst.

Source files
------------

// File: rtl/axi_mst_wr_stream.sv
// -----------------------------------------------------------------------------
// axi_mst_wr_stream
//   Streaming AXI write master. User commands and per-beat write data arrive on
//   separate handshake streams. Up to OST_DEPTH bursts are queued in a circular
//   buffer. Each burst goes through three stages, in order:
//     - AW issue
//     - W streaming, with WLAST generated from the burst length
//     - in-order B retirement to the user response port
//
// Optional feature (macro AXI_MST_WR_TIMEOUT_EN):
//   Adds the timeout_err output and a B-response watchdog limited by
//   TIMEOUT_CYC. The watchdog counts cycles spent waiting on an outstanding B.
//   Without the macro the port and counter do not exist and TIMEOUT_CYC is
//   unused.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/ready, cmd_*         burst command (id, addr, len, size, burst)
//   wd_valid/ready, wd_data/strb   write-beat stream (passed straight to W)
//   aw*                            AXI AW channel (payload of head AW entry)
//   wdata/wstrb/wlast/wvalid/wready  AXI W channel
//   bid/bresp/bvalid/bready        AXI B channel
//   rsp_valid/ready, rsp_id/resp   user completion stream
//   ost_cnt                        bursts accepted but not yet retired
//   err_id                         one-cycle pulse after a B whose bid mismatched
//   timeout_err                    sticky watchdog flag (only with the macro)
// -----------------------------------------------------------------------------
module axi_mst_wr_stream #(
    parameter int ID_W        = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int OST_DEPTH   = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ID_W-1:0]               cmd_id,
    input  logic [ADDR_W-1:0]             cmd_addr,
    input  logic [7:0]                    cmd_len,
    input  logic [2:0]                    cmd_size,
    input  logic [1:0]                    cmd_burst,
    input  logic                          wd_valid,
    output logic                          wd_ready,
    input  logic [DATA_W-1:0]             wd_data,
    input  logic [DATA_W/8-1:0]           wd_strb,
    output logic [ID_W-1:0]               awid,
    output logic [ADDR_W-1:0]             awaddr,
    output logic [7:0]                    awlen,
    output logic [2:0]                    awsize,
    output logic [1:0]                    awburst,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [DATA_W-1:0]             wdata,
    output logic [DATA_W/8-1:0]           wstrb,
    output logic                          wlast,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic [ID_W-1:0]               bid,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [1:0]                    rsp_resp,
    output logic [$clog2(OST_DEPTH):0]    ost_cnt,
    output logic                          err_id
`ifdef AXI_MST_WR_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);

    localparam int PTR_W = $clog2(OST_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OST_DEPTH);

    // Burst descriptor storage, written at command accept.
    logic [ID_W-1:0]   id_mem    [OST_DEPTH];
    logic [ADDR_W-1:0] addr_mem  [OST_DEPTH];
    logic [7:0]        len_mem   [OST_DEPTH];
    logic [2:0]        size_mem  [OST_DEPTH];
    logic [1:0]        burst_mem [OST_DEPTH];

    logic [PTR_W-1:0] alloc_ptr_reg, aw_ptr_reg, w_ptr_reg, b_ptr_reg;
    logic [CNT_W-1:0] ost_cnt_reg, aw_pend_reg, w_pend_reg, b_pend_reg;
    logic [CNT_W-1:0] ost_cnt_next, aw_pend_next, w_pend_next, b_pend_next;
    logic [7:0]       beat_cnt_reg, beat_cnt_next;
    logic             err_id_reg;

    logic cmd_hs, aw_hs, w_hs, wlast_hs, b_hs;
    logic w_open, b_open;

    assign w_open = (w_pend_reg != '0);
    assign b_open = (b_pend_reg != '0);

    // Only the registered count gates cmd_ready. A retire in the current
    // cycle therefore frees its slot one cycle later.
    assign cmd_ready = (ost_cnt_reg < DEPTH_C);

    assign awvalid = (aw_pend_reg != '0);
    assign awid    = id_mem[aw_ptr_reg];
    assign awaddr  = addr_mem[aw_ptr_reg];
    assign awlen   = len_mem[aw_ptr_reg];
    assign awsize  = size_mem[aw_ptr_reg];
    assign awburst = burst_mem[aw_ptr_reg];

    // W is a pass-through, gated until the head burst has completed its AW.
    assign wvalid   = wd_valid & w_open;
    assign wd_ready = wready & w_open;
    assign wdata    = wd_data;
    assign wstrb    = wd_strb;
    assign wlast    = wvalid & (beat_cnt_reg == len_mem[w_ptr_reg]);

    assign bready    = rsp_ready & b_open;
    assign rsp_valid = bvalid & b_open;
    assign rsp_id    = id_mem[b_ptr_reg];
    assign rsp_resp  = bresp;

    assign ost_cnt = ost_cnt_reg;
    assign err_id  = err_id_reg;

    assign cmd_hs   = cmd_valid & cmd_ready;
    assign aw_hs    = awvalid & awready;
    assign w_hs     = wvalid & wready;
    assign wlast_hs = w_hs & wlast;
    assign b_hs     = bvalid & bready;

    // Each stage counter is incremented by the stage before it and decremented
    // by its own handshake. A simultaneous +1 and -1 leaves it unchanged.
    always_comb begin
        ost_cnt_next  = ost_cnt_reg + CNT_W'(cmd_hs) - CNT_W'(b_hs);
        aw_pend_next  = aw_pend_reg + CNT_W'(cmd_hs) - CNT_W'(aw_hs);
        w_pend_next   = w_pend_reg + CNT_W'(aw_hs) - CNT_W'(wlast_hs);
        b_pend_next   = b_pend_reg + CNT_W'(wlast_hs) - CNT_W'(b_hs);
        beat_cnt_next = beat_cnt_reg;
        if (wlast_hs) begin
            beat_cnt_next = 8'd0;
        end else if (w_hs) begin
            beat_cnt_next = beat_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_hs) begin
            id_mem[alloc_ptr_reg]    <= cmd_id;
            addr_mem[alloc_ptr_reg]  <= cmd_addr;
            len_mem[alloc_ptr_reg]   <= cmd_len;
            size_mem[alloc_ptr_reg]  <= cmd_size;
            burst_mem[alloc_ptr_reg] <= cmd_burst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr_reg <= '0;
            aw_ptr_reg    <= '0;
            w_ptr_reg     <= '0;
            b_ptr_reg     <= '0;
            ost_cnt_reg   <= '0;
            aw_pend_reg   <= '0;
            w_pend_reg    <= '0;
            b_pend_reg    <= '0;
            beat_cnt_reg  <= '0;
            err_id_reg    <= 1'b0;
        end else begin
            if (cmd_hs)   alloc_ptr_reg <= alloc_ptr_reg + PTR_W'(1);
            if (aw_hs)    aw_ptr_reg    <= aw_ptr_reg + PTR_W'(1);
            if (wlast_hs) w_ptr_reg     <= w_ptr_reg + PTR_W'(1);
            if (b_hs)     b_ptr_reg     <= b_ptr_reg + PTR_W'(1);
            ost_cnt_reg  <= ost_cnt_next;
            aw_pend_reg  <= aw_pend_next;
            w_pend_reg   <= w_pend_next;
            b_pend_reg   <= b_pend_next;
            beat_cnt_reg <= beat_cnt_next;
            // A mismatching response is still retired; only flag it.
            err_id_reg   <= b_hs & (bid != id_mem[b_ptr_reg]);
        end
    end

`ifdef AXI_MST_WR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] wd_cnt_reg;
    logic            timeout_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (!b_open || b_hs) begin
                wd_cnt_reg <= '0;
            end else if (wd_cnt_reg != TO_LIM) begin
                wd_cnt_reg <= wd_cnt_reg + TO_W'(1);
            end
            if (wd_cnt_reg == TO_LIM) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`endif

endmodule
